// File: rtl/coeff_load_ctrl.sv
// rtl/coeff_load_ctrl.sv - buffers a host coefficient set and replays it as a gap-free SRAM write burst
module coeff_load_ctrl #(
  parameter int MAX_COEFF = 40,
  parameter int DW        = 16,
  parameter int AW        = 6
) (
  input  logic          iClk12M,
  input  logic          iRsn,
  input  logic          iCfgStart,
  input  logic [AW-1:0] iCfgNum,
  input  logic          iCfgValid,
  input  logic [DW-1:0] iCfgData,
  output logic          oCfgReady,
  input  logic          iHold,
  output logic          oCoeffUpdateFlag,
  output logic [AW-1:0] oAddrRam,
  output logic [DW-1:0] oWrDtRam,
  output logic [AW-1:0] oNumOfCoeff,
  output logic          oBusy,
  output logic          oDone,
  output logic          oErr
);

  localparam logic [AW-1:0] LP_MAX = AW'(MAX_COEFF);
  localparam logic [AW-1:0] LP_ONE = AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WAIT,
    ST_BURST,
    ST_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_num;
  logic [1:0]    r_gcnt;
  logic          r_err;
  logic [DW-1:0] r_mem [MAX_COEFF];

  logic          r_cfg_ready;
  logic          r_flag;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_done;

  logic          w_start_ok;
  logic          w_wr;
  logic          w_last_wr;
  logic          w_last_rd;
  logic          w_ready_nxt;
  logic          w_flag_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] w_data_nxt;
  logic          w_done_nxt;

  assign w_start_ok = iCfgStart && (iCfgNum != '0) && (iCfgNum <= LP_MAX);
  assign w_wr       = (r_state == ST_COLLECT) && iCfgValid && r_cfg_ready;
  assign w_last_wr  = w_wr && (r_wptr == (r_num - LP_ONE));
  assign w_last_rd  = (r_rptr == (r_num - LP_ONE));

  assign oCfgReady        = r_cfg_ready;
  assign oCoeffUpdateFlag = r_flag;
  assign oAddrRam         = r_addr;
  assign oWrDtRam         = r_data;
  assign oNumOfCoeff      = r_num;
  assign oBusy            = (r_state != ST_IDLE);
  assign oDone            = r_done;
  assign oErr             = r_err;

  // State register
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; GAP holds three state cycles because burst outputs trail the read pointer by one
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start_ok) w_next = ST_COLLECT;
      ST_COLLECT: if (w_last_wr)  w_next = ST_WAIT;
      ST_WAIT:    if (!iHold)     w_next = ST_BURST;
      ST_BURST:   if (w_last_rd)  w_next = ST_GAP;
      ST_GAP:     if (r_gcnt == 2'd2) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; addr/data are forced to zero outside the burst
  always_comb begin
    w_ready_nxt = (w_next == ST_COLLECT);
    w_flag_nxt  = (r_state == ST_BURST);
    w_addr_nxt  = '0;
    w_data_nxt  = '0;
    if (w_flag_nxt) begin
      w_addr_nxt = r_rptr;
      w_data_nxt = r_mem[r_rptr];
    end
    w_done_nxt  = (r_state == ST_GAP) && (r_gcnt == 2'd1);
  end

  // Output registers
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_cfg_ready <= 1'b0;
      r_flag      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_cfg_ready <= w_ready_nxt;
      r_flag      <= w_flag_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Pointers, gap counter, latched count and sticky error; pointers saturate at N-1
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_num  <= '0;
      r_gcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_start_ok) begin
        r_wptr <= '0;
        r_num  <= iCfgNum;
      end else if (w_wr && !w_last_wr) begin
        r_wptr <= r_wptr + LP_ONE;
      end

      if (r_state == ST_WAIT) begin
        r_rptr <= '0;
      end else if (r_state == ST_BURST && !w_last_rd) begin
        r_rptr <= r_rptr + LP_ONE;
      end

      if (r_state == ST_BURST) begin
        r_gcnt <= '0;
      end else if (r_state == ST_GAP) begin
        r_gcnt <= r_gcnt + 2'd1;
      end

      if (iCfgStart) begin
        r_err <= !((r_state == ST_IDLE) && w_start_ok);
      end
    end
  end

  // Coefficient buffer; contents survive reset and are only read after being written
  always_ff @(posedge iClk12M) begin
    if (iRsn && w_wr) begin
      r_mem[r_wptr] <= iCfgData;
    end
  end

endmodule

// File: doc/coeff_load_ctrl.md
Name: coeff_load_ctrl

Overview:
Upstream coefficient loader for the FIR filter controller. It accepts a coefficient set from the host over a valid/ready stream and buffers it in an internal register file. It then replays the set as one gap-free write burst (update flag, linear address, data, coefficient count) toward the SRAM-bank write controller. The burst contains no host stalls, so every SRAM write cycle carries valid data at a strictly incrementing address.

Parameters:
MAX_COEFF, 40, maximum coefficients per set (4 SRAM banks x 10 words)
DW, 16, coefficient data width
AW, 6, coefficient address/count width

Ports:
iClk12M  input  1  system clock, 12 MHz
iRsn  input  1  reset, synchronous, active-low
iCfgStart  input  1  single-cycle pulse; starts a new set, samples iCfgNum
iCfgNum  input  AW  number of coefficients in the set, valid with iCfgStart
iCfgValid  input  1  host coefficient word valid
iCfgData  input  DW  host coefficient word
oCfgReady  output  1  block accepts iCfgData this cycle
iHold  input  1  high = do not start a burst (filter busy)
oCoeffUpdateFlag  output  1  high during every burst write cycle
oAddrRam  output  AW  linear coefficient address 0..N-1
oWrDtRam  output  DW  coefficient data for oAddrRam
oNumOfCoeff  output  AW  coefficient count of the current or last set
oBusy  output  1  high whenever state is not IDLE
oDone  output  1  single-cycle pulse when a burst is complete
oErr  output  1  sticky error; cleared by the next accepted iCfgStart

Behaviour:
- One clock, iClk12M. Reset is synchronous and active-low on iRsn: sampled on the rising edge, and all state is cleared while iRsn=0.
- Reset values:
  - state = IDLE.
  - All outputs are 0, including oNumOfCoeff, oErr and oCfgReady.
  - Register-file contents are not reset and are never driven out before being written.
- All outputs are registered. oBusy is decoded from the state register.
- IDLE:
  - oCfgReady = 0.
  - iCfgStart with 1 <= iCfgNum <= MAX_COEFF: latch N = iCfgNum into oNumOfCoeff, clear the write pointer and oErr, go to COLLECT.
  - iCfgStart with iCfgNum = 0 or > MAX_COEFF: set oErr = 1, stay in IDLE, leave oNumOfCoeff unchanged.
- COLLECT:
  - oCfgReady = 1.
  - Each cycle with iCfgValid && oCfgReady: write iCfgData to mem[wptr], then wptr++.
  - The handshake that writes word N-1 moves to WAIT, and oCfgReady drops on the next edge.
  - iCfgValid with oCfgReady = 0 is ignored and drops no words.
- WAIT:
  - oCfgReady = 0.
  - Stay while iHold = 1. There is no timeout.
  - When iHold = 0, go to BURST with rptr = 0.
- BURST:
  - oCoeffUpdateFlag = 1 for exactly N consecutive cycles.
  - In burst cycle k (k = 0..N-1): oAddrRam = k and oWrDtRam = mem[k].
  - iHold is ignored once the burst has started.
  - After cycle N-1, go to GAP.
- GAP:
  - Lasts 2 cycles with oCoeffUpdateFlag = 0, oAddrRam = 0, oWrDtRam = 0.
  - oDone = 1 in the second GAP cycle, then go to IDLE.
- Latency:
  - Last COLLECT handshake at edge t, iHold = 0: first flag-high cycle at t+2.
  - First flag-high cycle at b: oDone at b+N+1, IDLE at b+N+2, new iCfgStart accepted from b+N+2.
- oNumOfCoeff holds N stable from COLLECT entry through GAP and afterwards, until the next accepted start. It is therefore valid in the first flag-high cycle.
- iCfgStart in any state other than IDLE: ignored, oErr = 1, the current operation continues unaffected.
- N = 1: a single flag-high cycle with addr 0.
- N = MAX_COEFF: addresses 0..39, no wrap. wptr and rptr never exceed N-1.
- Reset mid-operation (iRsn = 0 at any edge): the flag is low after that edge, state = IDLE, the partially loaded set is discarded, and no oDone is issued.

Test Plan:
- Reset, then start N=3 with data 0x0011, 0x0022, 0x0033, host valid every cycle, iHold=0 -> flag high 3 cycles starting t+2 with addr 0,1,2 / data 0x0011,0x0022,0x0033; oNumOfCoeff=3 throughout; oDone 2 cycles after last write.
- N=40 with host valid toggling every other cycle, data = 0x1000+k -> burst 40 consecutive flag-high cycles, addr 0..39, data 0x1000..0x1027, no gaps.
- N=5 loaded with iHold=1 for 20 cycles after the last handshake -> flag stays 0, oBusy=1 during hold; burst starts 1 cycle after iHold falls; raising iHold mid-burst does not interrupt the burst.
- iCfgStart with iCfgNum=0, then with 41 -> oErr=1, oBusy=0, no flag; next start with N=2 clears oErr and completes normally.
- iCfgStart pulsed during COLLECT (N=4) and again during BURST -> oErr=1, N stays 4, burst of 4 is unchanged.
- iRsn=0 for one edge in the middle of BURST (N=10, k=4) -> all outputs 0 next cycle, state IDLE, no oDone; a new start then works normally.
